// File: rtl/pd_crc_framer.sv
// pd_crc_framer: USB-PD transmit byte framer around an external crc32 engine.
// Forwards payload bytes downstream, feeds each accepted byte to the engine,
// then appends the four captured CRC bytes LSB first. Overlength packets are
// truncated at MAX_BYTES, flagged on err, and their tail is dropped.
// Optional build macro PD_CRC_INV_EN: when defined, the captured CRC is
// inverted here (final XOR done in the framer); when undefined, crc_i is
// taken as already final.
`timescale 1ns/1ps

module pd_crc_framer #(
    parameter int MAX_BYTES = 260,
    parameter int CRC_LAT   = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        crc_nrst,
    output logic        crc_en,
    output logic [7:0]  crc_din,
    input  logic [31:0] crc_i,
    output logic        err
);

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        DATA,
        WAIT,
        CRC,
        DROP
    } state_t;

    localparam logic [10:0] MAX_W    = 11'(MAX_BYTES);
    localparam logic [2:0]  LAT_LAST = 3'(CRC_LAT - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] sh_q, sh_d;
    logic [2:0]  idx_q, idx_d;
    logic        ovl_q, ovl_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_last_q, m_last_d;
    logic        crc_nrst_q, crc_nrst_d;
    logic        crc_en_q, crc_en_d;
    logic [7:0]  crc_din_q, crc_din_d;
    logic        err_q, err_d;

    logic [31:0] crc_cap;
    logic        slot_free;
    logic        s_ready_c;
    logic        accept;
    logic [10:0] cnt_inc;

`ifdef PD_CRC_INV_EN
    assign crc_cap = ~crc_i;
`else
    assign crc_cap = crc_i;
`endif

    // Handshake decode: the output slot is free when empty or draining now;
    // using m_ready directly keeps full throughput with a single output slot.
    always_comb begin
        slot_free = !m_valid_q || m_ready;
        s_ready_c = (((state_q == IDLE) || (state_q == DATA)) && slot_free)
                    || (state_q == DROP);
        accept    = s_valid && s_ready_c;
        cnt_inc   = {1'b0, cnt_q} + 11'd1;
    end

    // Next-state and next-output logic for the framing sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        ovl_d      = ovl_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        crc_en_d   = 1'b0;
        crc_din_d  = crc_din_q;
        err_d      = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            CLR: begin
                cnt_d   = '0;
                ovl_d   = 1'b0;
                state_d = IDLE;
            end
            IDLE, DATA: begin
                if (accept) begin
                    m_data_d  = s_data;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    crc_din_d = s_data;
                    crc_en_d  = 1'b1;
                    cnt_d     = cnt_inc[9:0];
                    state_d   = DATA;
                    if (s_last) begin
                        state_d = WAIT;
                        lat_d   = '0;
                    end else if (cnt_inc == MAX_W) begin
                        // Truncate: this byte closes the packet, the rest is dropped.
                        state_d = WAIT;
                        lat_d   = '0;
                        err_d   = 1'b1;
                        ovl_d   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = CRC;
                    if (slot_free) begin
                        // Present the first CRC byte straight from the capture.
                        m_data_d  = crc_cap[7:0];
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b0;
                        sh_d      = {8'h00, crc_cap[31:8]};
                        idx_d     = 3'd1;
                    end else begin
                        sh_d  = crc_cap;
                        idx_d = 3'd0;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            CRC: begin
                if (m_valid_q && m_ready && m_last_q) begin
                    state_d = ovl_q ? DROP : CLR;
                end else if (slot_free && (idx_q != 3'd4)) begin
                    m_data_d  = sh_q[7:0];
                    m_valid_d = 1'b1;
                    m_last_d  = (idx_q == 3'd3);
                    sh_d      = {8'h00, sh_q[31:8]};
                    idx_d     = idx_q + 3'd1;
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    state_d = CLR;
                end
            end
            default: state_d = CLR;
        endcase

        // The engine is held in clear for exactly the cycle spent in CLR.
        crc_nrst_d = (state_d != CLR);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before this edge.
        if (rst) begin
            state_q    <= CLR;
            cnt_q      <= '0;
            lat_q      <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            ovl_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'h00;
            m_last_q   <= 1'b0;
            crc_nrst_q <= 1'b0;
            crc_en_q   <= 1'b0;
            crc_din_q  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            ovl_q      <= ovl_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            crc_nrst_q <= crc_nrst_d;
            crc_en_q   <= crc_en_d;
            crc_din_q  <= crc_din_d;
            err_q      <= err_d;
        end
    end

    assign s_ready  = s_ready_c;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign crc_nrst = crc_nrst_q;
    assign crc_en   = crc_en_q;
    assign crc_din  = crc_din_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pd_crc_framer.sv
// Scoreboard bench for pd_crc_framer (MAX_BYTES=4, CRC_LAT=2). A behavioural
// crc32 engine or a constant stub drives crc_i; a negedge monitor pops the
// expected downstream bytes and checks handshake rules.
`timescale 1ns/1ps

module tb_pd_crc_framer;

    localparam int TB_MAX = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;
    typedef logic [7:0] bq_t[$];

    logic        clock;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        crc_nrst;
    logic        crc_en;
    logic [7:0]  crc_din;
    logic [31:0] crc_i;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    logic [7:0]  din_q[$];
    int          en_cnt  = 0;
    int          err_cnt = 0;
    logic        use_stub = 1'b0;
    int          mr_mode  = 1;
    logic [3:0]  mr_pat   = 4'b1001;
    logic [1:0]  ph       = 2'd0;
    logic [31:0] eng_q;
    logic [31:0] eng_out;

    pd_crc_framer #(.MAX_BYTES(TB_MAX), .CRC_LAT(2)) dut (
        .clock    (clock),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .crc_nrst (crc_nrst),
        .crc_en   (crc_en),
        .crc_din  (crc_din),
        .crc_i    (crc_i),
        .err      (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reflected CRC-32 (poly 0xEDB88320) one byte at a time.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_ref(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) c = crc_upd(c, b[k]);
        return ~c;
    endfunction

    // Behavioural crc32 engine: clears on low nrst, absorbs din on enable.
    always @(posedge clock) begin
        if (!crc_nrst) eng_q <= 32'hFFFFFFFF;
        else if (crc_en) eng_q <= crc_upd(eng_q, crc_din);
    end

`ifdef PD_CRC_INV_EN
    assign eng_out = eng_q;
`else
    assign eng_out = ~eng_q;
`endif
    assign crc_i   = use_stub ? 32'h12345678 : eng_out;
    assign m_ready = (mr_mode == 1) || ((mr_mode == 2) && mr_pat[ph]);

    initial begin
        forever begin
            @(posedge clock);
            #1;
            ph = ph + 2'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on each transfer, plus stall and ready rules.
    initial begin
        logic       stalled;
        logic [7:0] prev_d;
        logic       prev_l;
        exp_t       e;
        stalled = 1'b0;
        prev_d  = 8'h00;
        prev_l  = 1'b0;
        forever begin
            @(negedge clock);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (crc_en) begin
                    en_cnt++;
                    din_q.push_back(crc_din);
                end
                if (err) err_cnt++;
                if (stalled) begin
                    check("stall_valid", {31'b0, m_valid}, 32'd1);
                    check("stall_data", {24'b0, m_data}, {24'b0, prev_d});
                    check("stall_last", {31'b0, m_last}, {31'b0, prev_l});
                end
                if (m_valid && !m_ready) check("s_ready_while_full", {31'b0, s_ready}, 32'd0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %h last %b expected none", m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", {24'b0, m_data}, {24'b0, e.d});
                        check("m_last", {31'b0, m_last}, {31'b0, e.l});
                    end
                end
                stalled = m_valid && !m_ready;
                prev_d  = m_data;
                prev_l  = m_last;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit got;
        got     = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int t = 0; t < 64; t++) begin
            @(negedge clock);
            if (s_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("s_ready_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_pkt(input bq_t b, input logic stub, input bit finish);
        int          n_fwd;
        logic [31:0] w;
        exp_t        e;
        n_fwd = (b.size() > TB_MAX) ? TB_MAX : b.size();
        if (stub) begin
`ifdef PD_CRC_INV_EN
            w = ~32'h12345678;
`else
            w = 32'h12345678;
`endif
        end else begin
            w = crc_ref(b, n_fwd);
        end
        use_stub = stub;
        en_cnt   = 0;
        err_cnt  = 0;
        din_q.delete();
        for (int i = 0; i < n_fwd; i++) begin
            e.d = b[i];
            e.l = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e.d = w[8*i +: 8];
            e.l = (i == 3);
            exp_q.push_back(e);
        end
        for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
        if (finish) begin
            for (int t = 0; t < 200; t++) begin
                if (exp_q.size() == 0) break;
                @(posedge clock);
                #1;
            end
            check("drain", exp_q.size(), 32'd0);
            exp_q.delete();
            check("crc_en_pulses", en_cnt, n_fwd);
            for (int i = 0; i < n_fwd; i++) begin
                if (i < din_q.size()) check("crc_din", {24'b0, din_q[i]}, {24'b0, b[i]});
            end
            check("err_pulses", err_cnt, (b.size() > TB_MAX) ? 32'd1 : 32'd0);
            @(negedge clock);
            check("clr_nrst_low", {31'b0, crc_nrst}, 32'd0);
            check("clr_s_ready", {31'b0, s_ready}, 32'd0);
            @(negedge clock);
            check("idle_nrst_high", {31'b0, crc_nrst}, 32'd1);
            check("idle_s_ready", {31'b0, s_ready}, 32'd1);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
        check({tag, "_m_valid"}, {31'b0, m_valid}, 32'd0);
        check({tag, "_m_data"}, {24'b0, m_data}, 32'd0);
        check({tag, "_m_last"}, {31'b0, m_last}, 32'd0);
        check({tag, "_crc_nrst"}, {31'b0, crc_nrst}, 32'd0);
        check({tag, "_crc_en"}, {31'b0, crc_en}, 32'd0);
        check({tag, "_crc_din"}, {24'b0, crc_din}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        bq_t pkt;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        mr_mode = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("rst");
        @(posedge clock);
        #1;
        rst = 1'b0;

        // Single byte with stubbed CRC value.
        pkt = '{8'h4D};
        run_pkt(pkt, 1'b1, 1'b1);

        // Two bytes through the behavioural engine.
        pkt = '{8'h4D, 8'h00};
        run_pkt(pkt, 1'b0, 1'b1);

        // Downstream backpressure pattern 1,0,0,1 during payload and CRC.
        mr_mode = 2;
        pkt = '{8'hA1, 8'hB2, 8'hC3};
        run_pkt(pkt, 1'b0, 1'b1);
        mr_mode = 1;

        // Exactly MAX_BYTES with s_last: legal, no err.
        pkt = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_pkt(pkt, 1'b0, 1'b1);

        // Overlength: two extra bytes dropped, err once, CLR after s_last.
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_pkt(pkt, 1'b0, 1'b1);

        // Reset while the second CRC byte is presented.
        pkt = '{8'hA5};
        run_pkt(pkt, 1'b0, 1'b0);
        begin
            bit hit;
            hit = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (exp_q.size() == 3) begin
                    hit = 1'b1;
                    break;
                end
                @(posedge clock);
                #1;
            end
            check("second_crc_reached", {31'b0, hit}, 32'd1);
        end
        rst     = 1'b1;
        mr_mode = 0;
        @(posedge clock);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mr_mode = 1;
        @(negedge clock);
        check_reset_values("midrst");
        @(posedge clock);
        #1;

        // Next packet must use a freshly cleared engine.
        pkt = '{8'h3C, 8'h81};
        run_pkt(pkt, 1'b0, 1'b1);

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_idle_m_valid", {31'b0, m_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
